// File: rtl/alu_out_stage_pkg.sv
// ALU output stage shared definitions.
// Op encodings (also used by the ALU control decoder) and entry layout.
package alu_out_stage_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/alu_out_fifo.sv
// Small synchronous FIFO holding selected ALU results and flags.
// Caller guarantees push only when not full or when popping.
module alu_out_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; full+push+pop overwrites the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

endmodule

// File: rtl/alu_out_stage.sv
// ALU output stage: result select, flags, and output buffering.
// Tracks illegal ops with a sticky flag and a saturating counter.
module alu_out_stage
  import alu_out_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic [31:0] and_res,
  input  logic [31:0] or_res,
  input  logic [31:0] nor_res,
  input  logic [31:0] add_res,
  input  logic [31:0] sub_res,
  input  logic        a_msb,
  input  logic        b_msb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf,
  output logic        op_err,
  output logic [7:0]  err_cnt
);

  entry_t sel;
  entry_t head;
  logic   illegal;
  logic   slt_bit;
  logic   push;
  logic   pop;
  logic   empty;
  logic   full;

  assign slt_bit = (a_msb != b_msb) ? a_msb : sub_res[31];

  // Pick the result for this op and derive its flags.
  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (alu_op == OP_AND): sel.result = and_res;
      (alu_op == OP_OR):  sel.result = or_res;
      (alu_op == OP_NOR): sel.result = nor_res;
      (alu_op == OP_ADD): begin
        sel.result = add_res;
        sel.ovf    = (a_msb == b_msb) && (add_res[31] != a_msb);
      end
      (alu_op == OP_SUB): begin
        sel.result = sub_res;
        sel.ovf    = (a_msb != b_msb) && (sub_res[31] != a_msb);
      end
      (alu_op == OP_SLT): sel.result = {31'b0, slt_bit};
      default:            illegal    = 1'b1;
    endcase
    sel.zero = (sel.result == '0);
  end

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;

  alu_out_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (sel),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign result = out_valid ? head.result : '0;
  assign zero   = out_valid ? head.zero   : 1'b0;
  assign ovf    = out_valid ? head.ovf    : 1'b0;

  // Sticky error flag and saturating count of accepted illegal ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_err  <= 1'b0;
      err_cnt <= '0;
    end else if (push && illegal) begin
      op_err <= 1'b1;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
